instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle FSM that sequences the single-ALU datapath: FETCH, DECODE, EXEC, MEM, WB.
//  Consumes the decoder's control bits and turns the level signals RegWrite, MemWrite and IMemWrite
//  into single, handshaked strobes.
//  Drives PC update and IR load, counts retired instructions, and halts on request or bus timeout.
// PARAMETERS
//  CNT_W    32   width of retired-instruction counter
//  TO_W     8    width of memory-handshake timeout counter
//  TO_MAX   200  cycles waiting for an ack before bus_err (must be < 2**TO_W)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  run          in   1      pulse: leave HALT, begin fetching at current PC
//  halt_req     in   1      level: stop after the current instruction retires
//  imem_ack     in   1      instruction memory accepted/returned (read or write)
//  dmem_ack     in   1      data memory accepted/returned
//  ctl_regwrite in   1      decoder RegWrite
//  ctl_memwrite in   1      decoder MemWrite
//  ctl_imemwr   in   1      decoder IMemWrite
//  ctl_wdsrc    in   1      decoder WDSrc (1 = load: write data from dmem)
//  ctl_pcsrc    in   1      decoder PCSrc (jump/branch class)
//  br_cond      in   1      ALU result bit0, sampled in EXEC (datapath forces 1 for jtl)
//  imem_req     out  1      instruction memory request
//  imem_we      out  1      instruction memory write (qualifies imem_req)
//  dmem_req     out  1      data memory request
//  dmem_we      out  1      data memory write (qualifies dmem_req)
//  ir_load      out  1      load IR from imem read data
//  reg_we       out  1      register file write strobe
//  pc_en        out  1      PC register update strobe
//  pc_sel       out  1      0 = PC+1, 1 = branch target
//  halted       out  1      1 while in HALT
//  bus_err      out  1      sticky: handshake timeout occurred
//  state_o      out  3      current state encoding (debug)
//  retired      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - States: HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
//  - Reset (async, rst_n=0): state HALT, retired=0, bus_err=0, latched ctl=0, timeout=0.
//    All strobes are 0; halted=1. Reset mid-handshake drops requests immediately.
//  - HALT: run=1 -> FETCH and clear bus_err. Otherwise stay.
//  - FETCH: imem_req=1, imem_we=0. ack=1 in the same cycle -> ir_load=1 (that cycle only), go to DECODE.
//  - DECODE: 1 cycle. Latch ctl_* into internal regs at the end of the cycle; later states use only latched values.
//  - EXEC: 1 cycle. Latch br_taken = pcsrc_l & br_cond.
//    Any of memwrite_l, wdsrc_l or imemwr_l set -> MEM; else WB.
//  - MEM: if imemwr_l, drive imem_req=imem_we=1; else drive dmem_req=1 and dmem_we=memwrite_l.
//    Hold the request until the matching ack, then go to WB. The other memory's req stays 0.
//  - WB: 1 cycle. reg_we=regwrite_l. pc_en=1. pc_sel=br_taken.
//    retired increments by 1 (wraps at 2**CNT_W-1 -> 0).
//    Next state: halt_req=1 -> HALT; else FETCH.
//  - Timeout: the counter clears on entry to FETCH/MEM and increments each cycle a req is held without ack.
//    When it reaches TO_MAX: bus_err=1, drop the request, go to HALT with no WB, PC and retired unchanged.
//  - ack arrives in the same cycle as the TO_MAX compare: the ack wins and no error is raised.
//  - Acks are ignored outside FETCH/MEM. run is ignored outside HALT.
//  - If run and halt_req are both 1 in HALT: leave HALT, execute one instruction, return to HALT.
//  - All strobes are Moore outputs decoded from state plus latched ctl, except ir_load (FETCH & imem_ack).
//  - Latency with zero-wait acks: ALU op = 4 cycles (FETCH..WB); load/store/sImem = 5 cycles.
// TESTING
//  1. Reset, run pulse, add with ack tied 1 -> states 1,2,3,5. reg_we=1 and pc_en=1 in WB, pc_sel=0, retired=1.
//  2. lw, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, reg_we=1 in WB, retired=1.
//  3. beq with br_cond=1 then br_cond=0 -> pc_sel=1 then 0. reg_we=0, no dmem_req either time.
//  4. sImem -> imem_req=imem_we=1 in MEM, dmem_req=0 throughout. sw -> dmem_we=1, reg_we=0.
//  5. dmem_ack never arrives, TO_MAX=200 -> bus_err=1 after 200 MEM cycles, then HALT, no pc_en, retired unchanged.
//  6. halt_req=1 during EXEC -> WB retires, then HALT. Separately, drop rst_n mid-MEM -> all outputs at reset values at once.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Handshake/control bundle between the multi-cycle sequencer and its datapath/memories.
// The sequencer owns the requests and strobes; the environment owns acks and decoder bits.
interface instr_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             halt_req;
    logic             imem_ack;
    logic             dmem_ack;
    logic             ctl_regwrite;
    logic             ctl_memwrite;
    logic             ctl_imemwr;
    logic             ctl_wdsrc;
    logic             ctl_pcsrc;
    logic             br_cond;
    logic             imem_req;
    logic             imem_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_load;
    logic             reg_we;
    logic             pc_en;
    logic             pc_sel;
    logic             halted;
    logic             bus_err;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, halt_req, imem_ack, dmem_ack,
               ctl_regwrite, ctl_memwrite, ctl_imemwr, ctl_wdsrc, ctl_pcsrc, br_cond,
        output imem_req, imem_we, dmem_req, dmem_we, ir_load, reg_we,
               pc_en, pc_sel, halted, bus_err, state_o, retired
    );

    modport slave (
        output run, halt_req, imem_ack, dmem_ack,
               ctl_regwrite, ctl_memwrite, ctl_imemwr, ctl_wdsrc, ctl_pcsrc, br_cond,
        input  imem_req, imem_we, dmem_req, dmem_we, ir_load, reg_we,
               pc_en, pc_sel, halted, bus_err, state_o, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for a single-ALU datapath: one-shot strobes,
// handshake timeout to HALT with sticky bus_err, and a retired-instruction counter.
module instr_sequencer #(
    parameter int CNT_W  = 32,
    parameter int TO_W   = 8,
    parameter int TO_MAX = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             bus_err_q, bus_err_d;
    logic             rw_q, rw_d, mw_q, mw_d, iw_q, iw_d, wd_q, wd_d, pcs_q, pcs_d;
    logic             br_taken_q, br_taken_d;
    logic             mem_ack;
    logic             to_hit;

    // Only the memory actually being addressed in MEM can complete the handshake.
    assign mem_ack = iw_q ? bus.imem_ack : bus.dmem_ack;
    assign to_hit  = (to_q == TO_W'(TO_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HALT;
            retired_q  <= '0;
            to_q       <= '0;
            bus_err_q  <= 1'b0;
            rw_q       <= 1'b0;
            mw_q       <= 1'b0;
            iw_q       <= 1'b0;
            wd_q       <= 1'b0;
            pcs_q      <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            retired_q  <= retired_d;
            to_q       <= to_d;
            bus_err_q  <= bus_err_d;
            rw_q       <= rw_d;
            mw_q       <= mw_d;
            iw_q       <= iw_d;
            wd_q       <= wd_d;
            pcs_q      <= pcs_d;
            br_taken_q <= br_taken_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retired_d  = retired_q;
        to_d       = to_q;
        bus_err_d  = bus_err_q;
        rw_d       = rw_q;
        mw_d       = mw_q;
        iw_d       = iw_q;
        wd_d       = wd_q;
        pcs_d      = pcs_q;
        br_taken_d = br_taken_q;
        case (state_q)
            S_HALT: begin
                if (bus.run) begin
                    state_d   = S_FETCH;
                    bus_err_d = 1'b0;
                    to_d      = '0;
                end
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                rw_d    = bus.ctl_regwrite;
                mw_d    = bus.ctl_memwrite;
                iw_d    = bus.ctl_imemwr;
                wd_d    = bus.ctl_wdsrc;
                pcs_d   = bus.ctl_pcsrc;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                br_taken_d = pcs_q & bus.br_cond;
                if (mw_q | wd_q | iw_q) begin
                    state_d = S_MEM;
                    to_d    = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // An ack landing on the final timeout cycle still completes normally.
                if (mem_ack) begin
                    state_d = S_WB;
                end else if (to_hit) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            S_WB: begin
                retired_d = retired_q + CNT_W'(1);
                to_d      = '0;
                state_d   = bus.halt_req ? S_HALT : S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign bus.imem_req = (state_q == S_FETCH) | ((state_q == S_MEM) & iw_q);
    assign bus.imem_we  = (state_q == S_MEM) & iw_q;
    assign bus.dmem_req = (state_q == S_MEM) & ~iw_q;
    assign bus.dmem_we  = (state_q == S_MEM) & ~iw_q & mw_q;
    assign bus.ir_load  = (state_q == S_FETCH) & bus.imem_ack;
    assign bus.reg_we   = (state_q == S_WB) & rw_q;
    assign bus.pc_en    = (state_q == S_WB);
    assign bus.pc_sel   = (state_q == S_WB) & br_taken_q;
    assign bus.halted   = (state_q == S_HALT);
    assign bus.bus_err  = bus_err_q;
    assign bus.state_o  = state_q;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: directed vector table, hand-written timeout/reset sequences and
// random instructions checked against a per-instruction cycle/strobe-count model.
module tb_instr_sequencer;
    localparam int CNT_W  = 32;
    localparam int TO_MAX = 200;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_sequencer_if #(.CNT_W(CNT_W)) bus();
    instr_sequencer #(.CNT_W(CNT_W), .TO_W(8), .TO_MAX(TO_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        bit rw, mw, iw, wd, pcs, brc, hreq;
        int fdly, mdly;
    } ins_t;

    typedef struct {
        int cycles, imreq, imwe, dmreq, dmwe, regwe, pcen, pcsel, irload;
        int halted, berr;
    } obs_t;

    typedef struct {
        ins_t in;
        int cyc, imreq, imwe, dmreq, dmwe, regwe, pcsel;
    } vec_t;

    int errors = 0;
    int checks = 0;
    longint exp_ret = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Whole-instruction expectations from the cycle budget of each phase.
    function automatic obs_t model(input ins_t t);
        obs_t o;
        bit mem, tmo;
        int mc;
        mem = t.mw | t.wd | t.iw;
        tmo = mem && (t.mdly >= TO_MAX);
        mc  = tmo ? TO_MAX : t.mdly + 1;
        o.cycles = (t.fdly + 1) + 2 + (mem ? mc : 0) + (tmo ? 0 : 1);
        o.imreq  = (t.fdly + 1) + ((mem && t.iw) ? mc : 0);
        o.imwe   = (mem && t.iw) ? mc : 0;
        o.dmreq  = (mem && !t.iw) ? mc : 0;
        o.dmwe   = (mem && !t.iw && t.mw) ? mc : 0;
        o.regwe  = (!tmo && t.rw) ? 1 : 0;
        o.pcen   = tmo ? 0 : 1;
        o.pcsel  = (!tmo && t.pcs && t.brc) ? 1 : 0;
        o.irload = 1;
        o.halted = (tmo || t.hreq) ? 1 : 0;
        o.berr   = tmo ? 1 : 0;
        return o;
    endfunction

    // Runs one instruction from HALT or FETCH; decoder bits are only valid in DECODE,
    // br_cond only in EXEC, and unrelated inputs are randomised to prove they are ignored.
    task automatic do_instr(input ins_t t, output obs_t o);
        int fc, mc;
        bit seen_wb, done;
        logic [2:0] st;
        fc = 0; mc = 0; seen_wb = 0; done = 0;
        o = '{default: 0};
        if (bus.halted) begin
            bus.run = 1'b1;
            bus.halt_req = t.hreq;
            @(negedge clk);
            bus.run = 1'b0;
        end
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            st = bus.state_o;
            if (cyc > 0 && (st == 3'd0 || (seen_wb && st == 3'd1))) begin
                o.halted = int'(bus.halted);
                o.berr   = int'(bus.bus_err);
                done = 1;
            end else begin
                o.cycles++;
                if (bus.imem_req) o.imreq++;
                if (bus.imem_we)  o.imwe++;
                if (bus.dmem_req) o.dmreq++;
                if (bus.dmem_we)  o.dmwe++;
                if (bus.reg_we)   o.regwe++;
                if (bus.pc_en)    o.pcen++;
                if (bus.pc_sel)   o.pcsel++;
                if (st == 3'd5) seen_wb = 1;
                bus.ctl_regwrite = (st == 3'd2) ? t.rw  : 1'($urandom);
                bus.ctl_memwrite = (st == 3'd2) ? t.mw  : 1'($urandom);
                bus.ctl_imemwr   = (st == 3'd2) ? t.iw  : 1'($urandom);
                bus.ctl_wdsrc    = (st == 3'd2) ? t.wd  : 1'($urandom);
                bus.ctl_pcsrc    = (st == 3'd2) ? t.pcs : 1'($urandom);
                bus.br_cond      = (st == 3'd3) ? t.brc : 1'($urandom);
                bus.halt_req     = (st >= 3'd3) ? t.hreq : 1'($urandom);
                bus.run          = 1'($urandom);
                bus.imem_ack = bus.imem_req ? ((st == 3'd1) ? (fc == t.fdly) : (mc == t.mdly))
                                            : 1'($urandom);
                bus.dmem_ack = bus.dmem_req ? (mc == t.mdly) : 1'($urandom);
                if (st == 3'd1) fc++;
                if (st == 3'd4) mc++;
                #1;
                if (bus.ir_load) o.irload++;
                @(negedge clk);
            end
        end
        bus.run = 1'b0;
        chk("instr_done", longint'(done), 1);
    endtask

    task automatic chk_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, "_cycles"}, a.cycles, e.cycles);
        chk({tag, "_imreq"},  a.imreq,  e.imreq);
        chk({tag, "_imwe"},   a.imwe,   e.imwe);
        chk({tag, "_dmreq"},  a.dmreq,  e.dmreq);
        chk({tag, "_dmwe"},   a.dmwe,   e.dmwe);
        chk({tag, "_regwe"},  a.regwe,  e.regwe);
        chk({tag, "_pcen"},   a.pcen,   e.pcen);
        chk({tag, "_pcsel"},  a.pcsel,  e.pcsel);
        chk({tag, "_irload"}, a.irload, e.irload);
        chk({tag, "_halted"}, a.halted, e.halted);
        chk({tag, "_berr"},   a.berr,   e.berr);
    endtask

    initial begin
        vec_t tbl[10];
        obs_t o, e;
        ins_t t;
        bit reached;

        tbl[0] = '{'{1,0,0,0,0,0,0,0,0},   4,1,0,0,0,1,0};   // add
        tbl[1] = '{'{1,0,0,1,0,0,0,0,3},   8,1,0,4,0,1,0};   // lw, ack after 3 waits
        tbl[2] = '{'{0,0,0,0,1,1,0,0,0},   4,1,0,0,0,0,1};   // beq taken
        tbl[3] = '{'{0,0,0,0,1,0,0,0,0},   4,1,0,0,0,0,0};   // beq not taken
        tbl[4] = '{'{0,0,1,0,0,0,0,0,0},   5,2,1,0,0,0,0};   // sImem
        tbl[5] = '{'{0,1,0,0,0,0,0,0,1},   6,1,0,2,2,0,0};   // sw, one wait
        tbl[6] = '{'{1,0,0,0,0,0,1,2,0},   6,3,0,0,0,1,0};   // add, slow fetch, halt after
        tbl[7] = '{'{1,0,0,0,0,0,1,0,0},   4,1,0,0,0,1,0};   // run+halt together
        tbl[8] = '{'{1,0,0,0,1,1,0,0,0},   4,1,0,0,0,1,1};   // jtl
        tbl[9] = '{'{1,0,0,1,0,0,0,0,199}, 204,1,0,200,0,1,0}; // ack on last timeout cycle

        rst_n = 1'b0;
        bus.run = 0; bus.halt_req = 0; bus.imem_ack = 0; bus.dmem_ack = 0;
        bus.ctl_regwrite = 0; bus.ctl_memwrite = 0; bus.ctl_imemwr = 0;
        bus.ctl_wdsrc = 0; bus.ctl_pcsrc = 0; bus.br_cond = 0;
        #12;
        chk("rst_state",   bus.state_o, 0);
        chk("rst_halted",  bus.halted, 1);
        chk("rst_strobes", {bus.imem_req, bus.imem_we, bus.dmem_req, bus.dmem_we,
                            bus.reg_we, bus.pc_en, bus.pc_sel}, 0);
        chk("rst_retired", bus.retired, 0);
        chk("rst_berr",    bus.bus_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_ack = 1; bus.dmem_ack = 1;
        repeat (3) @(negedge clk);
        chk("idle_no_run", bus.state_o, 0);

        for (int i = 0; i < 10; i++) begin
            do_instr(tbl[i].in, o);
            exp_ret++;
            chk($sformatf("vec%0d_cycles", i), o.cycles, tbl[i].cyc);
            chk($sformatf("vec%0d_imreq", i),  o.imreq,  tbl[i].imreq);
            chk($sformatf("vec%0d_imwe", i),   o.imwe,   tbl[i].imwe);
            chk($sformatf("vec%0d_dmreq", i),  o.dmreq,  tbl[i].dmreq);
            chk($sformatf("vec%0d_dmwe", i),   o.dmwe,   tbl[i].dmwe);
            chk($sformatf("vec%0d_regwe", i),  o.regwe,  tbl[i].regwe);
            chk($sformatf("vec%0d_pcsel", i),  o.pcsel,  tbl[i].pcsel);
            chk($sformatf("vec%0d_pcen", i),   o.pcen,   1);
            chk($sformatf("vec%0d_irload", i), o.irload, 1);
            chk($sformatf("vec%0d_halted", i), o.halted, int'(tbl[i].in.hreq));
            chk($sformatf("vec%0d_berr", i),   o.berr,   0);
            chk($sformatf("vec%0d_retired", i), bus.retired, exp_ret);
        end

        // dmem never acks: timeout to HALT, nothing retires
        t = '{1,0,0,1,0,0,0,0,100000};
        do_instr(t, o);
        chk_obs("tmo", o, model(t));
        chk("tmo_retired", bus.retired, exp_ret);

        // run from the error HALT clears bus_err
        t = '{1,0,0,0,0,0,0,0,0};
        do_instr(t, o);
        exp_ret++;
        chk_obs("post_tmo", o, model(t));
        chk("post_tmo_retired", bus.retired, exp_ret);

        for (int i = 0; i < 40; i++) begin
            t.rw = 1'($urandom); t.mw = 1'($urandom); t.iw = 1'($urandom);
            t.wd = 1'($urandom); t.pcs = 1'($urandom); t.brc = 1'($urandom);
            t.hreq = ($urandom_range(0, 3) == 0);
            t.fdly = $urandom_range(0, 3);
            t.mdly = $urandom_range(0, 4);
            do_instr(t, o);
            e = model(t);
            exp_ret += e.pcen;
            chk_obs($sformatf("rnd%0d", i), o, e);
            chk($sformatf("rnd%0d_retired", i), bus.retired, exp_ret);
        end

        // reset asserted while a load sits in MEM
        bus.ctl_regwrite = 1; bus.ctl_wdsrc = 1; bus.ctl_memwrite = 0; bus.ctl_imemwr = 0;
        bus.ctl_pcsrc = 0; bus.halt_req = 0; bus.imem_ack = 1; bus.dmem_ack = 0;
        if (bus.halted) begin
            bus.run = 1;
            @(negedge clk);
            bus.run = 0;
        end
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            if (bus.state_o == 3'd4) reached = 1;
            else @(negedge clk);
        end
        chk("rstmem_reach", longint'(reached), 1);
        chk("rstmem_req_before", bus.dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmem_state",   bus.state_o, 0);
        chk("rstmem_halted",  bus.halted, 1);
        chk("rstmem_strobes", {bus.imem_req, bus.imem_we, bus.dmem_req, bus.dmem_we,
                               bus.reg_we, bus.pc_en, bus.pc_sel}, 0);
        chk("rstmem_retired", bus.retired, 0);
        chk("rstmem_berr",    bus.bus_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
